// File: rtl/stump_sequencer.sv
// Stump processor control sequencer.
// Walks each instruction through FETCH, EXECUTE and an optional MEMORY phase,
// then parks in HALT or starts the next fetch. Supports free-run, single-step,
// halt requests and a memory wait timeout that raises a sticky bus error.
module stump_sequencer #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        step,
  input  logic        halt_req,
  input  logic        is_ldst,
  input  logic        mem_ready,
  output logic [1:0]  state,
  output logic        mem_req,
  output logic        advance,
  output logic        ir_load,
  output logic        halted,
  output logic        bus_error,
  output logic [15:0] instr_count
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'b00,
    S_EXECUTE = 2'b01,
    S_MEMORY  = 2'b10,
    S_HALT    = 2'b11
  } state_t;

  // The wait counter trips on the cycle it would reach TIMEOUT.
  localparam logic [7:0] LP_LAST_WAIT = TIMEOUT - 8'd1;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_wait_cnt;
  logic        r_step_mode;
  logic        r_bus_error;
  logic [15:0] r_count;
  logic        w_mem_phase;
  logic        w_waiting;
  logic        w_retire;
  logic        w_timeout;
  logic        w_set_step;

  assign w_mem_phase = (r_state == S_FETCH) || (r_state == S_MEMORY);
  assign w_waiting   = w_mem_phase && !mem_ready;

  // Next-state decision: phase progression, retire boundary and timeout abort.
  always_comb begin
    w_next     = r_state;
    w_retire   = 1'b0;
    w_timeout  = 1'b0;
    w_set_step = 1'b0;
    case (r_state)
      S_HALT: begin
        if (!r_bus_error) begin
          if (step) begin
            w_next     = S_FETCH;
            w_set_step = 1'b1;
          end else if (run && !halt_req) begin
            w_next = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (mem_ready) begin
          w_next = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (is_ldst) begin
          w_next = S_MEMORY;
        end else begin
          w_retire = 1'b1;
        end
      end
      S_MEMORY: begin
        if (mem_ready) begin
          w_retire = 1'b1;
        end
      end
      default: w_next = S_HALT;
    endcase
    if (w_waiting && (r_wait_cnt == LP_LAST_WAIT)) begin
      w_timeout = 1'b1;
      w_next    = S_HALT;
    end
    if (w_retire) begin
      w_next = (run && !halt_req && !r_step_mode) ? S_FETCH : S_HALT;
    end
  end

  // State register; reset parks the sequencer in HALT and abandons any access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_HALT;
    end else begin
      r_state <= w_next;
    end
  end

  // Consecutive memory wait cycles, restarted whenever the phase changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= 8'd0;
    end else if (w_next != r_state) begin
      r_wait_cnt <= 8'd0;
    end else if (w_waiting) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  // Sticky bus error; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bus_error <= 1'b0;
    end else if (w_timeout) begin
      r_bus_error <= 1'b1;
    end
  end

  // Single-step flag: armed by an accepted step, dropped when the instruction retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step_mode <= 1'b0;
    end else if (w_set_step) begin
      r_step_mode <= 1'b1;
    end else if (w_retire) begin
      r_step_mode <= 1'b0;
    end
  end

  // Retired instruction counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 16'd0;
    end else if (w_retire) begin
      r_count <= r_count + 16'd1;
    end
  end

  // Output decode; strobes only fire in FETCH/MEMORY when memory answers, or in EXECUTE.
  always_comb begin
    state       = r_state;
    halted      = (r_state == S_HALT);
    bus_error   = r_bus_error;
    instr_count = r_count;
    mem_req     = w_mem_phase;
    ir_load     = (r_state == S_FETCH) && mem_ready;
    advance     = (r_state == S_EXECUTE) || (w_mem_phase && mem_ready);
  end

endmodule

// File: tb/tb_stump_sequencer.sv
// Self-checking bench for the Stump control sequencer.
// A cycle-level behavioural model is compared against the DUT on every falling
// edge, and directed scenarios pin the model with hand-computed values.
module tb_stump_sequencer;

  localparam int TIMEOUT = 4;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        step;
  logic        haltReq;
  logic        isLdst;
  logic        memReady;
  logic [1:0]  state;
  logic        memReq;
  logic        advance;
  logic        irLoad;
  logic        halted;
  logic        busError;
  logic [15:0] instrCount;

  int nCompared = 0;
  int nMismatch = 0;
  logic checkEn;
  logic preloadReq;

  // Samples captured at the falling edge of each driven cycle.
  logic [1:0]  sState;
  logic        sAdv;
  logic        sHalted;
  logic        sBusErr;
  logic [15:0] sCount;

  // Behavioural model state: phase code 0=fetch 1=execute 2=memory 3=halt.
  logic [1:0]  mSt;
  logic [1:0]  mNxt;
  logic [15:0] mCount;
  logic        mBusErr;
  logic        mStepMode;
  int          mWait;
  logic        mRetire;

  logic [1:0] expRun [10];
  logic [1:0] expSeq [5];
  int memCycles;
  int memAdv;

  stump_sequencer #(.TIMEOUT(8'd4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .step       (step),
    .halt_req   (haltReq),
    .is_ldst    (isLdst),
    .mem_ready  (memReady),
    .state      (state),
    .mem_req    (memReq),
    .advance    (advance),
    .ir_load    (irLoad),
    .halted     (halted),
    .bus_error  (busError),
    .instr_count(instrCount)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: advance one instruction phase per clock from the sequencing rules.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mSt = 2'd3;
      mCount = 16'd0;
      mBusErr = 1'b0;
      mStepMode = 1'b0;
      mWait = 0;
    end else begin
      mNxt = mSt;
      mRetire = 1'b0;
      if (mSt == 2'd3) begin
        if (!mBusErr && (step || (run && !haltReq))) begin
          mStepMode = step;
          mNxt = 2'd0;
        end
      end else if (mSt == 2'd1) begin
        if (isLdst) mNxt = 2'd2;
        else mRetire = 1'b1;
      end else if (!memReady) begin
        if (mWait + 1 == TIMEOUT) begin
          mBusErr = 1'b1;
          mNxt = 2'd3;
        end
      end else if (mSt == 2'd0) begin
        mNxt = 2'd1;
      end else begin
        mRetire = 1'b1;
      end
      if (mRetire) begin
        mCount = mCount + 16'd1;
        mNxt = (run && !haltReq && !mStepMode) ? 2'd0 : 2'd3;
        mStepMode = 1'b0;
      end
      if (mNxt != mSt) mWait = 0;
      else if ((mSt == 2'd0 || mSt == 2'd2) && !memReady) mWait = mWait + 1;
      mSt = mNxt;
      if (preloadReq) mCount = 16'hFFFF;
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model in the middle of each cycle.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("cyc_state", {14'd0, state}, {14'd0, mSt});
      checkOutput("cyc_halted", {15'd0, halted}, {15'd0, (mSt == 2'd3)});
      checkOutput("cyc_mem_req", {15'd0, memReq}, {15'd0, (mSt == 2'd0 || mSt == 2'd2)});
      checkOutput("cyc_ir_load", {15'd0, irLoad}, {15'd0, (mSt == 2'd0 && memReady)});
      checkOutput("cyc_advance", {15'd0, advance},
                  {15'd0, (mSt == 2'd1 || ((mSt == 2'd0 || mSt == 2'd2) && memReady))});
      checkOutput("cyc_bus_error", {15'd0, busError}, {15'd0, mBusErr});
      checkOutput("cyc_count", instrCount, mCount);
    end
  end

  // Drive one cycle of inputs, sample outputs mid-cycle, then step past the edge.
  task automatic applyStimulus(input logic r, input logic s, input logic h, input logic l, input logic m);
    run = r;
    step = s;
    haltReq = h;
    isLdst = l;
    memReady = m;
    @(negedge clk);
    sState = state;
    sAdv = advance;
    sHalted = halted;
    sBusErr = busError;
    sCount = instrCount;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    run = 1'b0;
    step = 1'b0;
    haltReq = 1'b0;
    isLdst = 1'b0;
    memReady = 1'b0;
    checkEn = 1'b1;
    preloadReq = 1'b0;
    expRun = '{2'd3, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", {14'd0, state}, 16'h3);
    checkOutput("reset_mem_req", {15'd0, memReq}, 16'h0);
    checkOutput("reset_count", instrCount, 16'h0);
    rst_n = 1'b1;

    // Free-run ALU instructions at two cycles each.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("run_seq_state", {14'd0, sState}, {14'd0, expRun[i]});
    end
    checkOutput("run_seq_count", sCount, 16'd4);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("run_stop_halted", {15'd0, sHalted}, 16'h1);
    checkOutput("run_stop_count", sCount, 16'd5);

    // Load/store with three memory wait cycles.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    memCycles = 0;
    memAdv = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, (i == 3));
      if (sState == 2'd2) memCycles++;
      if (sState == 2'd2 && sAdv) memAdv++;
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("ldst_mem_cycles", memCycles[15:0], 16'd4);
    checkOutput("ldst_mem_advances", memAdv[15:0], 16'd1);
    checkOutput("ldst_count", sCount, 16'd6);
    checkOutput("ldst_halted", {15'd0, sHalted}, 16'h1);

    // Single step; a second step during EXECUTE is ignored.
    expSeq = '{2'd3, 2'd0, 2'd1, 2'd3, 2'd3};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, (i == 0 || i == 2), 1'b0, 1'b0, 1'b1);
      checkOutput("step_seq_state", {14'd0, sState}, {14'd0, expSeq[i]});
    end
    checkOutput("step_count", sCount, 16'd7);

    // Step together with halt_req still executes exactly one instruction.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("step_halt_state", {14'd0, sState}, 16'h3);
    checkOutput("step_halt_count", sCount, 16'd8);

    // halt_req raised in FETCH of a load/store lets it finish, then halt wins over run.
    expSeq = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, (i != 0), 1'b1, 1'b1);
      checkOutput("haltreq_seq_state", {14'd0, sState}, {14'd0, expSeq[i]});
    end
    checkOutput("haltreq_count", sCount, 16'd9);

    // Counter wrap from a preloaded all-ones value.
    checkEn = 1'b0;
    preloadReq = 1'b1;
    force dut.r_count = 16'hFFFF;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    release dut.r_count;
    preloadReq = 1'b0;
    checkEn = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("wrap_preload", sCount, 16'hFFFF);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("wrap_count", sCount, 16'h0000);

    // Reset asserted mid-MEMORY abandons the access immediately.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    memReady = 1'b1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mem_state", {14'd0, state}, 16'h3);
    checkOutput("rst_mem_halted", {15'd0, halted}, 16'h1);
    checkOutput("rst_mem_mem_req", {15'd0, memReq}, 16'h0);
    checkOutput("rst_mem_advance", {15'd0, advance}, 16'h0);
    checkOutput("rst_mem_ir_load", {15'd0, irLoad}, 16'h0);
    checkOutput("rst_mem_bus_error", {15'd0, busError}, 16'h0);
    checkOutput("rst_mem_count", instrCount, 16'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fetch timeout after four wait cycles, then run and step are locked out.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("tmo_wait_state", {14'd0, sState}, 16'h0);
      checkOutput("tmo_wait_no_error", {15'd0, sBusErr}, 16'h0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("tmo_bus_error", {15'd0, sBusErr}, 16'h1);
    checkOutput("tmo_halted", {15'd0, sHalted}, 16'h1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("tmo_locked_state", {14'd0, sState}, 16'h3);
    checkOutput("tmo_count", sCount, 16'h0);
    rst_n = 1'b0;
    #1;
    checkOutput("tmo_reset_clears", {15'd0, busError}, 16'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("tmo_recover_state", {14'd0, sState}, 16'h0);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkEn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
